cam_pipelined: RTL and testbench

- Parametrised, pipelined successor to the 32x32 CAM.
- Adds per-entry valid bits, auto-allocating insert, per-entry invalidate, occupancy tracking and a registered two-stage search pipeline.
- Sits in the same lookup path as the current CAM. Accepts one search per cycle at full throughput.

---
 rtl/cam_pipelined.sv | 173 +++++++++++++++++
 tb/tb_cam_pipelined.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pipelined.sv
// Pipelined CAM with valid bits, auto-insert, invalidate, occupancy count; CAM_MULTIHIT_EN adds search_multi_o.
// Latency: read 1 cycle, insert_done 1 cycle, search result 2 cycles; one search accepted per cycle.
// No backpressure: requests always accepted, one mutation per cycle (write > insert > invalidate), insert dropped when full.
module cam_pipelined #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_enable_i,
    input  logic [ADDR_WIDTH-1:0] read_index_i,
    output logic                  read_valid_o,
    output logic [WIDTH-1:0]      read_value_o,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_index_i,
    input  logic [WIDTH-1:0]      write_data_i,
    input  logic                  insert_enable_i,
    input  logic [WIDTH-1:0]      insert_data_i,
    output logic                  insert_done_o,
    output logic [ADDR_WIDTH-1:0] insert_index_o,
    input  logic                  inval_enable_i,
    input  logic [ADDR_WIDTH-1:0] inval_index_i,
    input  logic                  search_enable_i,
    input  logic [WIDTH-1:0]      search_data_i,
    output logic                  search_valid_o,
    output logic                  search_hit_o,
    output logic [ADDR_WIDTH-1:0] search_index_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
`ifdef CAM_MULTIHIT_EN
    ,
    output logic                  search_multi_o
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0]      rd_val_q, rd_val_d;
    logic                  ins_done_q, ins_done_d;
    logic [ADDR_WIDTH-1:0] ins_idx_q, ins_idx_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [DEPTH-1:0]      s1_match_q, s1_match_d;
    logic                  s2_vld_q, s2_vld_d;
    logic                  hit_q, hit_d;
    logic [ADDR_WIDTH-1:0] sidx_q, sidx_d;
`ifdef CAM_MULTIHIT_EN
    logic                  multi_q, multi_d;
`endif

    logic                  full;
    logic [ADDR_WIDTH-1:0] free_idx;
    logic [DEPTH-1:0]      match;

    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        free_idx = '0;
        match    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = ADDR_WIDTH'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (mem_q[i] == search_data_i);
        end
    end

    // Mutations: all decisions use pre-edge valid/count so reads and searches see old contents.
    always_comb begin
        mem_d      = mem_q;
        valid_d    = valid_q;
        count_d    = count_q;
        ins_done_d = 1'b0;
        ins_idx_d  = ins_idx_q;
        if (write_enable_i) begin
            mem_d[write_index_i]   = write_data_i;
            valid_d[write_index_i] = 1'b1;
            if (!valid_q[write_index_i]) count_d = count_q + CNT_W'(1);
        end else if (insert_enable_i) begin
            if (!full) begin
                mem_d[free_idx]   = insert_data_i;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + CNT_W'(1);
                ins_done_d        = 1'b1;
                ins_idx_d         = free_idx;
            end
        end else if (inval_enable_i) begin
            valid_d[inval_index_i] = 1'b0;
            if (valid_q[inval_index_i]) count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        rd_vld_d   = read_enable_i ? valid_q[read_index_i] : rd_vld_q;
        rd_val_d   = read_enable_i ? mem_q[read_index_i] : rd_val_q;
        s1_vld_d   = search_enable_i;
        s1_match_d = search_enable_i ? match : s1_match_q;
        s2_vld_d   = s1_vld_q;
        hit_d      = hit_q;
        sidx_d     = sidx_q;
        if (s1_vld_q) begin
            hit_d  = |s1_match_q;
            sidx_d = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (s1_match_q[i]) sidx_d = ADDR_WIDTH'(i);
            end
        end
`ifdef CAM_MULTIHIT_EN
        multi_d = multi_q;
        // Clearing the lowest set bit leaves something only when two or more bits were set.
        if (s1_vld_q) multi_d = ((s1_match_q & (s1_match_q - DEPTH'(1))) != '0);
`endif
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= '0;
            count_q    <= '0;
            rd_vld_q   <= 1'b0;
            rd_val_q   <= '0;
            ins_done_q <= 1'b0;
            ins_idx_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_match_q <= '0;
            s2_vld_q   <= 1'b0;
            hit_q      <= 1'b0;
            sidx_q     <= '0;
`ifdef CAM_MULTIHIT_EN
            multi_q    <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_vld_q   <= rd_vld_d;
            rd_val_q   <= rd_val_d;
            ins_done_q <= ins_done_d;
            ins_idx_q  <= ins_idx_d;
            s1_vld_q   <= s1_vld_d;
            s1_match_q <= s1_match_d;
            s2_vld_q   <= s2_vld_d;
            hit_q      <= hit_d;
            sidx_q     <= sidx_d;
`ifdef CAM_MULTIHIT_EN
            multi_q    <= multi_d;
`endif
        end
    end

    assign read_valid_o   = rd_vld_q;
    assign read_value_o   = rd_val_q;
    assign insert_done_o  = ins_done_q;
    assign insert_index_o = ins_idx_q;
    assign search_valid_o = s2_vld_q;
    assign search_hit_o   = hit_q;
    assign search_index_o = sidx_q;
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = (count_q == '0);
`ifdef CAM_MULTIHIT_EN
    assign search_multi_o = multi_q;
`endif

endmodule

// File: tb/tb_cam_pipelined.sv
// Bench for cam_pipelined: directed steps then random traffic against an array-based reference model.
module tb_cam_pipelined;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          read_enable_i = 1'b0;
    logic [AW-1:0] read_index_i = '0;
    logic          read_valid_o;
    logic [W-1:0]  read_value_o;
    logic          write_enable_i = 1'b0;
    logic [AW-1:0] write_index_i = '0;
    logic [W-1:0]  write_data_i = '0;
    logic          insert_enable_i = 1'b0;
    logic [W-1:0]  insert_data_i = '0;
    logic          insert_done_o;
    logic [AW-1:0] insert_index_o;
    logic          inval_enable_i = 1'b0;
    logic [AW-1:0] inval_index_i = '0;
    logic          search_enable_i = 1'b0;
    logic [W-1:0]  search_data_i = '0;
    logic          search_valid_o;
    logic          search_hit_o;
    logic [AW-1:0] search_index_o;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          empty_o;
`ifdef CAM_MULTIHIT_EN
    logic          search_multi_o;
`endif

    always #5 clk_i = ~clk_i;

    cam_pipelined #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .read_enable_i(read_enable_i), .read_index_i(read_index_i),
        .read_valid_o(read_valid_o), .read_value_o(read_value_o),
        .write_enable_i(write_enable_i), .write_index_i(write_index_i), .write_data_i(write_data_i),
        .insert_enable_i(insert_enable_i), .insert_data_i(insert_data_i),
        .insert_done_o(insert_done_o), .insert_index_o(insert_index_o),
        .inval_enable_i(inval_enable_i), .inval_index_i(inval_index_i),
        .search_enable_i(search_enable_i), .search_data_i(search_data_i),
        .search_valid_o(search_valid_o), .search_hit_o(search_hit_o), .search_index_o(search_index_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
`ifdef CAM_MULTIHIT_EN
        , .search_multi_o(search_multi_o)
`endif
    );

    // Reference model: table contents, valid flags, expected (held) outputs, one-deep search queue.
    logic [W-1:0] m_data [D];
    bit           m_vld  [D];
    bit           e_rv;
    logic [W-1:0] e_rval;
    bit           e_idone;
    int           e_iidx;
    bit           e_hit;
    int           e_sidx;
    bit           p_v, p_hit;
    int           p_idx;
`ifdef CAM_MULTIHIT_EN
    bit           e_multi, p_multi;
`endif
    int n_cmp = 0;
    int n_err = 0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_vld[i]);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit n_v, n_hit;
        int n_idx, nm, f;
        if (read_enable_i) begin
            e_rv   = m_vld[read_index_i];
            e_rval = m_data[read_index_i];
        end
        n_v = search_enable_i;
        n_idx = 0;
        nm = 0;
        for (int i = 0; i < D; i++) begin
            if (m_vld[i] && m_data[i] == search_data_i) begin
                if (nm == 0) n_idx = i;
                nm++;
            end
        end
        n_hit = (nm > 0);
        e_idone = 0;
        if (write_enable_i) begin
            m_data[write_index_i] = write_data_i;
            m_vld[write_index_i]  = 1;
        end else if (insert_enable_i) begin
            if (m_count() < D) begin
                f = D;
                for (int i = D - 1; i >= 0; i--) if (!m_vld[i]) f = i;
                m_data[f] = insert_data_i;
                m_vld[f]  = 1;
                e_idone   = 1;
                e_iidx    = f;
            end
        end else if (inval_enable_i) begin
            m_vld[inval_index_i] = 0;
        end
        @(posedge clk_i);
        #1;
        if (p_v) begin
            e_hit  = p_hit;
            e_sidx = p_idx;
`ifdef CAM_MULTIHIT_EN
            e_multi = p_multi;
`endif
        end
        chk("search_valid", 64'(search_valid_o), 64'(p_v));
        chk("search_hit", 64'(search_hit_o), 64'(e_hit));
        chk("search_index", 64'(search_index_o), 64'(e_sidx));
`ifdef CAM_MULTIHIT_EN
        chk("search_multi", 64'(search_multi_o), 64'(e_multi));
        p_multi = (nm >= 2);
`endif
        p_v = n_v; p_hit = n_hit; p_idx = n_idx;
        chk("read_valid", 64'(read_valid_o), 64'(e_rv));
        if (e_rv) chk("read_value", 64'(read_value_o), 64'(e_rval));
        chk("insert_done", 64'(insert_done_o), 64'(e_idone));
        if (e_idone) chk("insert_index", 64'(insert_index_o), 64'(e_iidx));
        chk("count", 64'(count_o), 64'(m_count()));
        chk("full", 64'(full_o), 64'(m_count() == D));
        chk("empty", 64'(empty_o), 64'(m_count() == 0));
    endtask

    task automatic idle_inputs();
        read_enable_i = 0; write_enable_i = 0; insert_enable_i = 0;
        inval_enable_i = 0; search_enable_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b0;
        #1;
        chk("rst_search_valid", 64'(search_valid_o), 64'd0);
        chk("rst_search_hit", 64'(search_hit_o), 64'd0);
        chk("rst_search_index", 64'(search_index_o), 64'd0);
        chk("rst_read_valid", 64'(read_valid_o), 64'd0);
        chk("rst_read_value", 64'(read_value_o), 64'd0);
        chk("rst_insert_done", 64'(insert_done_o), 64'd0);
        chk("rst_insert_index", 64'(insert_index_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
`ifdef CAM_MULTIHIT_EN
        chk("rst_search_multi", 64'(search_multi_o), 64'd0);
        e_multi = 0; p_multi = 0;
`endif
        for (int i = 0; i < D; i++) m_vld[i] = 0;
        e_rv = 0; e_rval = '0; e_idone = 0; e_iidx = 0;
        e_hit = 0; e_sidx = 0; p_v = 0; p_hit = 0; p_idx = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();

        // Fill by insert, then one insert past full.
        insert_enable_i = 1;
        for (int i = 0; i < D; i++) begin
            insert_data_i = 32'h100 + 32'(i);
            tick();
            chk("fill_insert_index", 64'(insert_index_o), 64'(i));
        end
        chk("fill_full", 64'(full_o), 64'd1);
        insert_data_i = 32'h999;
        tick();
        chk("overfill_no_done", 64'(insert_done_o), 64'd0);
        chk("overfill_count", 64'(count_o), 64'd32);
        insert_enable_i = 0;

        // Directed write then hit and miss searches.
        write_enable_i = 1; write_index_i = 5; write_data_i = 32'hDEADBEEF;
        tick();
        write_enable_i = 0;
        search_enable_i = 1; search_data_i = 32'hDEADBEEF;
        tick();
        search_data_i = 32'h12345678;
        tick();
        search_enable_i = 0;
        chk("hit_valid", 64'(search_valid_o), 64'd1);
        chk("hit_flag", 64'(search_hit_o), 64'd1);
        chk("hit_index", 64'(search_index_o), 64'd5);
        tick();
        chk("miss_flag", 64'(search_hit_o), 64'd0);
        chk("miss_index", 64'(search_index_o), 64'd0);

        // Duplicate keys resolve to the lowest index; invalidate exposes the next.
        write_enable_i = 1; write_data_i = 32'hAAAA; write_index_i = 3;
        tick();
        write_index_i = 9;
        tick();
        write_enable_i = 0;
        search_enable_i = 1; search_data_i = 32'hAAAA;
        tick();
        search_enable_i = 0;
        tick();
        chk("dup_index", 64'(search_index_o), 64'd3);
`ifdef CAM_MULTIHIT_EN
        chk("dup_multi", 64'(search_multi_o), 64'd1);
`endif
        inval_enable_i = 1; inval_index_i = 3;
        tick();
        inval_enable_i = 0;
        chk("inval_count", 64'(count_o), 64'd31);
        search_enable_i = 1;
        tick();
        search_enable_i = 0;
        tick();
        chk("after_inval_index", 64'(search_index_o), 64'd9);

        // Write, insert and invalidate together: only the write lands.
        write_enable_i = 1; write_index_i = 7; write_data_i = 32'h777;
        insert_enable_i = 1; insert_data_i = 32'h555;
        inval_enable_i = 1; inval_index_i = 2;
        tick();
        idle_inputs();
        chk("prio_no_insert", 64'(insert_done_o), 64'd0);
        chk("prio_count", 64'(count_o), 64'd31);
        read_enable_i = 1; read_index_i = 2;
        tick();
        read_enable_i = 0;
        chk("prio_idx2_valid", 64'(read_valid_o), 64'd1);

        // Back-to-back searches give back-to-back results.
        write_enable_i = 1; write_index_i = 3; write_data_i = 32'h103;
        tick();
        write_enable_i = 0;
        for (int k = 0; k < 6; k++) begin
            search_enable_i = (k < 4);
            search_data_i = 32'h100 + 32'(k);
            tick();
            if (k >= 1 && k <= 4) begin
                chk("b2b_valid", 64'(search_valid_o), 64'd1);
                chk("b2b_index", 64'(search_index_o), 64'(k - 1));
            end
        end

        // Reset with searches in flight.
        search_enable_i = 1; search_data_i = 32'h100;
        tick();
        search_data_i = 32'h101;
        tick();
        do_reset();
        read_enable_i = 1; read_index_i = 5;
        tick();
        read_enable_i = 0;
        chk("post_rst_read_valid", 64'(read_valid_o), 64'd0);
        chk("post_rst_search_valid", 64'(search_valid_o), 64'd0);
        tick();
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            write_enable_i  = ($urandom % 8) == 0;
            write_index_i   = AW'($urandom);
            write_data_i    = 32'h1000 + ($urandom % 4);
            insert_enable_i = ($urandom % 3) == 0;
            insert_data_i   = 32'h1000 + ($urandom % 4);
            inval_enable_i  = ($urandom % 3) == 0;
            inval_index_i   = AW'($urandom);
            read_enable_i   = ($urandom % 2) == 0;
            read_index_i    = AW'($urandom);
            search_enable_i = ($urandom % 2) == 0;
            search_data_i   = 32'h1000 + ($urandom % 5);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
